// File: rtl/wform_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wform_pkg
// Description : Shared constants and state encoding for the waveform sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package wform_pkg;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int REPS_W = 4;
  localparam int DIV_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wform_pattern_mem.sv
`default_nettype none
// ============================================================================
// Module      : wform_pattern_mem
// Description : DEPTH x DW pattern store, synchronous write, bit-wise async read.
// Revision    : 1.0 - initial release
// ============================================================================
module wform_pattern_mem #(
  parameter int DEPTH = wform_pkg::DEPTH,
  parameter int AW    = wform_pkg::AW,
  parameter int DW    = wform_pkg::DW
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_byte,
  input  logic [2:0]    i_rd_bit,
  output logic          o_rd_bit
);

  import wform_pkg::*;

  // Deliberately unreset: pattern contents survive a sequencer reset.
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_bit = r_mem[i_rd_byte][i_rd_bit];

endmodule
`default_nettype wire

// File: rtl/wform_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wform_seq_ctrl
// Description : Start/stop sequencer playing pattern bytes LSB-first on wform.
// Revision    : 1.0 - initial release
// ============================================================================
module wform_seq_ctrl #(
  parameter int DEPTH = wform_pkg::DEPTH,
  parameter int AW    = wform_pkg::AW,
  parameter int DW    = wform_pkg::DW
) (
  input  logic                         clk,
  input  logic                         clear_neg,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DW-1:0]                wr_data,
  input  logic                         start,
  input  logic [AW-1:0]                len,
  input  logic [wform_pkg::REPS_W-1:0] reps,
  input  logic [wform_pkg::DIV_W-1:0]  div,
  input  logic                         stop,
  output logic                         wform,
  output logic                         busy,
  output logic                         done,
  output logic [AW-1:0]                byte_idx,
  output logic [2:0]                   bit_idx
);

  import wform_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_len;
  logic [AW-1:0]     r_byte;
  logic [REPS_W-1:0] r_reps;
  logic [REPS_W-1:0] r_pass;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_cnt;
  logic [2:0]        r_bit;

  logic w_start;
  logic w_stop;
  logic w_mem_wr;
  logic w_period_end;
  logic w_byte_end;
  logic w_pass_end;
  logic w_final;
  logic w_mem_bit;

  assign w_start      = (r_state == IDLE) && start;
  assign w_stop       = (r_state == PLAY) && stop;
  assign w_mem_wr     = (r_state == IDLE) && wr_en;
  assign w_period_end = (r_cnt == r_div);
  assign w_byte_end   = w_period_end && (r_bit == 3'd7);
  assign w_pass_end   = w_byte_end && (r_byte == r_len);
  // reps == 0 never reaches the final pass, so play loops until stopped.
  assign w_final      = w_pass_end && (r_reps != '0) && (r_pass == REPS_W'(1));

  wform_pattern_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_wr),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_byte (r_byte),
    .i_rd_bit  (r_bit),
    .o_rd_bit  (w_mem_bit)
  );

  always_ff @(posedge clk or negedge clear_neg) begin
    if (!clear_neg) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = PLAY;
      PLAY:    if (stop || w_final) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_neg) begin
    if (!clear_neg) begin
      r_len  <= '0;
      r_reps <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_byte <= '0;
      r_pass <= '0;
    end else if (w_start) begin
      r_len  <= len;
      r_reps <= reps;
      r_div  <= div;
      r_cnt  <= '0;
      r_bit  <= '0;
      r_byte <= '0;
      r_pass <= reps;
    end else if ((r_state == PLAY) && !w_stop) begin
      if (w_period_end) begin
        r_cnt <= '0;
        r_bit <= r_bit + 3'd1;
        if (w_pass_end) begin
          r_byte <= '0;
          if (r_reps != '0) begin
            r_pass <= r_pass - REPS_W'(1);
          end
        end else if (w_byte_end) begin
          r_byte <= r_byte + AW'(1);
        end
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  assign wform    = (r_state == PLAY) && w_mem_bit;
  assign busy     = (r_state == PLAY);
  assign done     = (r_state == DONE);
  assign byte_idx = r_byte;
  assign bit_idx  = r_bit;

endmodule
`default_nettype wire

// File: doc/wform_seq_ctrl.md
# wform_seq_ctrl

Sequencer for the serial waveform generator. Holds an 8×8 pattern memory and plays its bytes out LSB-first on `wform`, one bit per programmable bit period. Bytes are replayed for a programmed number of repetitions under a start/stop/done handshake. It replaces the free-running counter pair with a host-controllable, loadable, stoppable sequencer.

## Interface
Parameters:
- `DEPTH`, 8, number of pattern bytes (power of two).
- `AW`, 3, address width, log2(DEPTH).
- `DW`, 8, pattern byte width (bits per byte).

Ports:
- `clk`, in, 1, single clock; all state changes on its rising edge.
- `clear_neg`, in, 1, reset, asynchronous and active-low.
- `wr_en`, in, 1, pattern write strobe; honoured only in IDLE.
- `wr_addr`, in, AW, pattern write address.
- `wr_data`, in, DW, pattern write data.
- `start`, in, 1, play request; sampled in IDLE only.
- `len`, in, AW, last byte index to play (bytes played = len+1); latched on start.
- `reps`, in, 4, passes over bytes 0..len; 0 = repeat until stop; latched on start.
- `div`, in, 4, bit period = div+1 clocks; latched on start.
- `stop`, in, 1, abort request; honoured only in PLAY.
- `wform`, out, 1, serial waveform.
- `busy`, out, 1, high while in PLAY.
- `done`, out, 1, one-cycle pulse at end of play (normal or aborted).
- `byte_idx`, out, AW, byte currently playing.
- `bit_idx`, out, 3, bit currently playing.

## Operation
- States:
  - IDLE → PLAY on `start`.
  - PLAY → DONE on final bit-period expiry or on `stop`.
  - DONE → IDLE unconditionally, after 1 cycle.
- On reset:
  - state=IDLE.
  - `wform`, `busy`, `done`, `byte_idx`, `bit_idx` all 0.
  - Latched len/reps/div and the period counter are 0.
  - Pattern memory is not reset; contents are retained across reset.
- On `start` in IDLE:
  - Latch len, reps, div.
  - Clear `byte_idx`, `bit_idx` and the period counter.
  - Load the pass counter with reps.
- In PLAY, `wform` = mem[`byte_idx`][`bit_idx`]. `wform` is forced to 0 in IDLE and DONE.
- The period counter counts 0..div. On reaching div it returns to 0 and advances `bit_idx`.
- `bit_idx` wraps 7→0 and advances `byte_idx`.
- `byte_idx` wraps from len→0, which ends one pass:
  - If reps≠0, the pass counter decrements. The pass that takes it 1→0 is final, and the state goes to DONE instead of wrapping.
  - If reps=0, wrapping continues indefinitely.
- `stop` in PLAY → DONE on the next edge, regardless of bit position. There is no completion of the current byte.
- `start` outside IDLE is ignored. `stop` outside PLAY is ignored.
- `wr_en` outside IDLE is ignored; memory is unchanged.
- `wr_en` and `start` in the same IDLE cycle: the write commits at that edge, so play uses the new data.
- Reset mid-PLAY: returns immediately to the reset values. No `done` pulse is produced.
- Arithmetic: all counters are unsigned and wrap modulo their width. No overflow flags.

## Timing
- `start` sampled at edge k: `busy`=1 and `wform`=mem[0][0] from edge k through edge k+div+1.
- Each bit is held exactly div+1 cycles. Normal play length = (len+1)·8·(div+1)·reps cycles.
- The final bit period ends at edge e: `done`=1 and `busy`=0 for cycle e..e+1, then IDLE. `start` is accepted from edge e+1.
- `stop` sampled at edge s: DONE at edge s, `wform`=0 from edge s.
- Memory write: visible to play from the edge after it is sampled.

## Structure
- Shared package `wform_pkg`:
  - state enum {IDLE, PLAY, DONE}.
  - Constants `DEPTH`, `AW`, `DW`, `REPS_W`=4, `DIV_W`=4.
- Sub-module `wform_pattern_mem`: DEPTH×DW register array, one synchronous write port, combinational read of one bit by (byte, bit) index. No reset.
- Top level contains the FSM, the period counter, the bit/byte indices and the pass counter.

## Test plan
- Write mem[0]=8'hCC, mem[1]=8'hAA; start with len=1, reps=1, div=0:
  - `wform` bits 0,0,1,1,0,0,1,1,0,1,0,1,0,1,0,1 on consecutive cycles.
  - `done` pulses at cycle 16 after start.
- Same memory, div=3, len=0, reps=2:
  - Each bit held 4 cycles; byte 0xCC is played twice.
  - `done` after 64 cycles.
- reps=0, len=0, div=0:
  - Play continues past 100 cycles.
  - `stop` at cycle 37 → `wform`=0, `busy`=0 and `done`=1 at the next edge.
- `wr_en` to addr 0 with 8'hFF during PLAY:
  - Ignored; the current and subsequent plays output the old mem[0].
- `clear_neg` pulsed low mid-PLAY:
  - All outputs 0 asynchronously, with no `done` pulse.
  - A following start replays memory unchanged.
- `start` asserted during PLAY and DONE is ignored. `start` and `wr_en` to addr 0 (8'h01) in the same IDLE cycle → the first `wform` bit is 1.
